// File: rtl/spi_cpu_arb_pkg.sv
// Shared types and register map for the SPI/CPU memory arbiter.
package spi_cpu_arb_pkg;
    typedef enum logic [1:0] {
        RSEL_NONE    = 2'd0,
        RSEL_CPU     = 2'd1,
        RSEL_SPI_MEM = 2'd2,
        RSEL_SPI_CTL = 2'd3
    } rsel_t;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_STALL_L = 2'd2;
    localparam logic [1:0] REG_STALL_H = 2'd3;

    localparam int CTRL_HALT    = 0;
    localparam int CTRL_CPU_RST = 1;
endpackage

// File: rtl/spi_cpu_arb_regs.sv
// Control/status register file reachable from the SPI bridge: CTRL, STATUS and
// the saturating CPU stall counter, with a registered read port.
module spi_cpu_arb_regs
    import spi_cpu_arb_pkg::*;
#(
    parameter logic [1:0] CTRL_RESET = 2'b00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ctl_en,
    input  logic        i_ctl_wr,
    input  logic [22:0] i_ctl_addr,
    input  logic [1:0]  i_ctl_wdata,
    input  logic        i_cpu_req,
    input  logic        i_spi_mem,
    output logic        o_halt,
    output logic        o_cpu_rst_bit,
    output logic [7:0]  o_ctl_rdata
);
    logic [1:0]  r_ctrl;
    logic [15:0] r_stall;
    logic [7:0]  r_rdata;
    logic        w_sel;
    logic        w_wr;
    logic        w_sat;
    logic        w_inc;
    logic [7:0]  w_rd;

    assign w_sel = (i_ctl_addr[22:2] == '0);
    assign w_wr  = i_ctl_en & i_ctl_wr & w_sel;
    assign w_sat = &r_stall;
    assign w_inc = i_cpu_req & i_spi_mem & ~r_ctrl[CTRL_HALT] & ~r_ctrl[CTRL_CPU_RST];

    // Read value is taken from pre-update state so a counter read never sees its own cycle
    always_comb begin
        w_rd = 8'h00;
        if (w_sel) begin
            case (i_ctl_addr[1:0])
                REG_CTRL:    w_rd = {6'b0, r_ctrl};
                REG_STATUS:  w_rd = {5'b0, w_sat, i_cpu_req, |r_ctrl};
                REG_STALL_L: w_rd = r_stall[7:0];
                default:     w_rd = r_stall[15:8];
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ctrl  <= CTRL_RESET;
            r_stall <= '0;
            r_rdata <= '0;
        end else begin
            if (w_wr && i_ctl_addr[1:0] == REG_CTRL)
                r_ctrl <= i_ctl_wdata;
            if (w_wr && i_ctl_addr[1:0] == REG_STALL_L)
                r_stall <= '0;
            else if (w_inc && !w_sat)
                r_stall <= r_stall + 16'd1;
            if (i_ctl_en)
                r_rdata <= w_rd;
        end
    end

    assign o_halt        = r_ctrl[CTRL_HALT];
    assign o_cpu_rst_bit = r_ctrl[CTRL_CPU_RST];
    assign o_ctl_rdata   = r_rdata;
endmodule

// File: rtl/spi_cpu_mem_arbiter.sv
// Single-port SRAM arbiter: the SPI bridge always wins, the 6502 is held off via RDY.
// Also routes registered read data back to whichever side issued the access.
module spi_cpu_mem_arbiter
    import spi_cpu_arb_pkg::*;
#(
    parameter int         ADDR_W     = 16,
    parameter logic [1:0] CTRL_RESET = 2'b00
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [7:0]        i_cpu_do,
    output logic [7:0]        o_cpu_di,
    output logic              o_cpu_rdy,
    output logic              o_cpu_rst,
    input  logic [23:0]       i_spi_addr,
    input  logic              i_spi_en,
    input  logic              i_spi_wr,
    input  logic [7:0]        i_spi_wdata,
    output logic [7:0]        o_spi_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_en,
    output logic              o_mem_wr,
    output logic [7:0]        o_mem_wdata,
    input  logic [7:0]        i_mem_rdata
);
    logic       w_spi_mem, w_spi_ctl, w_cpu_go;
    logic       w_halt, w_crst_bit;
    logic [7:0] w_ctl_rdata, w_spi_ret;
    rsel_t      w_rsel_d, r_rsel;
    logic       r_cpu_ret;
    logic [7:0] r_cpu_hold, r_spi_hold;

    assign w_spi_mem = i_spi_en & i_spi_addr[23];
    assign w_spi_ctl = i_spi_en & ~i_spi_addr[23];
    assign o_cpu_rdy = ~i_rst & ~w_spi_mem & ~w_halt & ~w_crst_bit;
    assign o_cpu_rst = i_rst | w_crst_bit;
    assign w_cpu_go  = i_cpu_req & o_cpu_rdy;

    spi_cpu_arb_regs #(.CTRL_RESET(CTRL_RESET)) u_regs (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_ctl_en      (w_spi_ctl),
        .i_ctl_wr      (i_spi_wr),
        .i_ctl_addr    (i_spi_addr[22:0]),
        .i_ctl_wdata   (i_spi_wdata[1:0]),
        .i_cpu_req     (i_cpu_req),
        .i_spi_mem     (w_spi_mem),
        .o_halt        (w_halt),
        .o_cpu_rst_bit (w_crst_bit),
        .o_ctl_rdata   (w_ctl_rdata)
    );

    always_comb begin
        o_mem_addr  = i_cpu_addr;
        o_mem_en    = 1'b0;
        o_mem_wr    = 1'b0;
        o_mem_wdata = i_cpu_do;
        if (w_spi_mem && !i_rst) begin
            o_mem_addr  = i_spi_addr[ADDR_W-1:0];
            o_mem_en    = 1'b1;
            o_mem_wr    = i_spi_wr;
            o_mem_wdata = i_spi_wdata;
        end else if (w_cpu_go) begin
            o_mem_en = 1'b1;
            o_mem_wr = i_cpu_we;
        end
    end

    // A control access never stalls the CPU, so both may complete in one cycle;
    // the CPU return is therefore tracked in its own flag alongside rsel.
    assign w_rsel_d = w_spi_mem ? RSEL_SPI_MEM :
                      w_spi_ctl ? RSEL_SPI_CTL :
                      w_cpu_go  ? RSEL_CPU     : RSEL_NONE;

    always_comb begin
        case (r_rsel)
            RSEL_SPI_MEM: w_spi_ret = i_mem_rdata;
            RSEL_SPI_CTL: w_spi_ret = w_ctl_rdata;
            default:      w_spi_ret = r_spi_hold;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsel     <= RSEL_NONE;
            r_cpu_ret  <= 1'b0;
            r_cpu_hold <= '0;
            r_spi_hold <= '0;
        end else begin
            r_rsel    <= w_rsel_d;
            r_cpu_ret <= w_cpu_go;
            if (r_cpu_ret)
                r_cpu_hold <= i_mem_rdata;
            if (r_rsel == RSEL_SPI_MEM || r_rsel == RSEL_SPI_CTL)
                r_spi_hold <= w_spi_ret;
        end
    end

    assign o_cpu_di    = i_rst ? 8'h00 : (r_cpu_ret ? i_mem_rdata : r_cpu_hold);
    assign o_spi_rdata = i_rst ? 8'h00 : w_spi_ret;
endmodule

// File: tb/tb_spi_cpu_mem_arbiter.sv
// Randomized + directed bench for spi_cpu_mem_arbiter against a cycle-level reference model.
module tb_spi_cpu_mem_arbiter;
    localparam int         AW   = 16;
    localparam logic [1:0] CRST = 2'b00;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [AW-1:0] c_addr = '0;
    logic          c_req = 1'b0, c_we = 1'b0;
    logic [7:0]    c_do = '0;
    logic [23:0]   s_addr = '0;
    logic          s_en = 1'b0, s_wr = 1'b0;
    logic [7:0]    s_wd = '0;
    logic [7:0]    o_cpu_di, o_spi_rdata, o_mem_wdata, mem_rdata;
    logic          o_cpu_rdy, o_cpu_rst, o_mem_en, o_mem_wr;
    logic [AW-1:0] o_mem_addr;

    spi_cpu_mem_arbiter #(.ADDR_W(AW), .CTRL_RESET(CRST)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_addr(c_addr), .i_cpu_req(c_req), .i_cpu_we(c_we), .i_cpu_do(c_do),
        .o_cpu_di(o_cpu_di), .o_cpu_rdy(o_cpu_rdy), .o_cpu_rst(o_cpu_rst),
        .i_spi_addr(s_addr), .i_spi_en(s_en), .i_spi_wr(s_wr), .i_spi_wdata(s_wd),
        .o_spi_rdata(o_spi_rdata),
        .o_mem_addr(o_mem_addr), .o_mem_en(o_mem_en), .o_mem_wr(o_mem_wr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
    );

    function automatic logic [7:0] pat(int a);
        case (a)
            16'h0407: return 8'h77;
            16'h0409: return 8'h99;
            16'h040A: return 8'hAA;
            16'h040B: return 8'hBB;
            16'h040C: return 8'hCC;
            default:  return 8'((a & 8'hFF) ^ (a >> 8) ^ 8'h5A);
        endcase
    endfunction

    // SRAM: registered read, written data appears on rdata
    logic [7:0] sram [65536];
    bit         wrt  [65536];
    initial mem_rdata = 8'h00;
    always @(posedge clk) begin
        if (o_mem_en) begin
            if (o_mem_wr) begin
                sram[o_mem_addr] <= o_mem_wdata;
                wrt[o_mem_addr]  <= 1'b1;
                mem_rdata        <= o_mem_wdata;
            end else begin
                mem_rdata <= wrt[o_mem_addr] ? sram[o_mem_addr] : pat(int'(o_mem_addr));
            end
        end
    end

    // Reference model state
    logic [7:0] rmem [65536];
    bit         m_halt, m_crst;
    int         m_stall;
    bit         cp_v, sp_v;
    logic [7:0] cp_d, sp_d, c_hold, s_hold;
    int         n_chk = 0, n_pass = 0;
    logic [7:0] smp_spi, smp_di;
    logic       smp_rdy, smp_en, smp_crst;

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    endtask

    function automatic logic [7:0] reg_val(logic [22:0] a, bit req);
        if (a[22:2] != 0) return 8'h00;
        case (a[1:0])
            2'd0:    return {6'b0, m_crst, m_halt};
            2'd1:    return {5'b0, m_stall == 65535, req, m_halt | m_crst};
            2'd2:    return m_stall[7:0];
            default: return m_stall[15:8];
        endcase
    endfunction

    task automatic cycle();
        bit smem, sctl, rdy, en, inc, clr;
        logic [7:0] edi, esp;
        @(negedge clk);
        smem = s_en && s_addr[23];
        sctl = s_en && !s_addr[23];
        rdy  = !rst && !smem && !m_halt && !m_crst;
        en   = !rst && (smem || (c_req && rdy));
        edi  = rst ? 8'h00 : (cp_v ? cp_d : c_hold);
        esp  = rst ? 8'h00 : (sp_v ? sp_d : s_hold);
        chk("cpu_rdy", o_cpu_rdy, rdy);
        chk("mem_en", o_mem_en, en);
        chk("cpu_rst", o_cpu_rst, rst | m_crst);
        chk("cpu_di", o_cpu_di, edi);
        chk("spi_rdata", o_spi_rdata, esp);
        if (en) begin
            chk("mem_wr", o_mem_wr, smem ? s_wr : c_we);
            chk("mem_addr", o_mem_addr, smem ? s_addr[AW-1:0] : c_addr);
            if (o_mem_wr) chk("mem_wdata", o_mem_wdata, smem ? s_wd : c_do);
        end
        smp_spi = o_spi_rdata; smp_di = o_cpu_di; smp_rdy = o_cpu_rdy;
        smp_en = o_mem_en; smp_crst = o_cpu_rst;
        @(posedge clk);
        if (rst) begin
            m_halt = CRST[0]; m_crst = CRST[1]; m_stall = 0;
            cp_v = 0; sp_v = 0; c_hold = 0; s_hold = 0;
        end else begin
            c_hold = edi; s_hold = esp;
            cp_v = c_req && rdy;
            if (cp_v) begin
                cp_d = c_we ? c_do : rmem[c_addr];
                if (c_we) rmem[c_addr] = c_do;
            end
            sp_v = s_en;
            inc = c_req && smem && !m_halt && !m_crst;
            clr = 0;
            if (smem) begin
                sp_d = s_wr ? s_wd : rmem[s_addr[AW-1:0]];
                if (s_wr) rmem[s_addr[AW-1:0]] = s_wd;
            end
            if (sctl) begin
                sp_d = reg_val(s_addr[22:0], c_req);
                if (s_wr && s_addr[22:2] == 0) begin
                    if (s_addr[1:0] == 2'd0) begin m_halt = s_wd[0]; m_crst = s_wd[1]; end
                    if (s_addr[1:0] == 2'd2) clr = 1;
                end
            end
            if (clr) m_stall = 0;
            else if (inc && m_stall < 65535) m_stall++;
        end
        #1;
    endtask

    task automatic spi(input logic [23:0] a, input bit w, input logic [7:0] d);
        s_en = 1; s_addr = a; s_wr = w; s_wd = d;
        cycle();
        s_en = 0; s_wr = 0;
    endtask

    task automatic rd_ctl(input logic [1:0] off, output logic [7:0] v);
        spi({22'h0, off}, 0, 8'h00);
        cycle();
        v = smp_spi;
    endtask

    logic [7:0] burst [4];
    logic [7:0] v;

    initial begin
        for (int i = 0; i < 65536; i++) rmem[i] = pat(i);
        burst[0] = 8'h99; burst[1] = 8'hAA; burst[2] = 8'hBB; burst[3] = 8'hCC;

        rst = 1; cycle(); cycle();
        chk("reset_rdy", smp_rdy, 0);
        chk("reset_crst", smp_crst, 1);
        rst = 0;

        // CPU-only read
        c_req = 1; c_addr = 16'h0407; c_we = 0; cycle();
        chk("t1_en", smp_en, 1); chk("t1_rdy", smp_rdy, 1);
        c_req = 0; cycle();
        chk("t1_di", smp_di, 8'h77);

        // SPI burst against a requesting CPU
        c_req = 1; c_addr = 16'h0407;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin s_en = 1; s_addr = 24'h800409 + 24'(k); s_wr = 0; end
            else s_en = 0;
            cycle();
            if (k < 4) chk("t2_stall", smp_rdy, 0); else chk("t2_resume", smp_rdy, 1);
            if (k > 0) chk("t2_rdata", smp_spi, burst[k-1]);
        end
        c_req = 0;
        rd_ctl(2'd2, v); chk("t2_stall_l", v, 8'h04);

        // Halt via CTRL
        spi(24'h0, 1, 8'h01);
        c_req = 1; cycle(); chk("t3_halt", smp_rdy, 0);
        rd_ctl(2'd1, v); chk("t3_status0", v[0], 1);
        spi(24'h800409, 0, 0);
        rd_ctl(2'd2, v); chk("t3_no_count", v, 8'h04);
        spi(24'h0, 1, 8'h00);
        cycle(); chk("t3_resume", smp_rdy, 1);

        // CPU reset via CTRL; SPI memory still usable
        spi(24'h0, 1, 8'h02);
        cycle(); chk("t4_crst", smp_crst, 1); chk("t4_rdy", smp_rdy, 0);
        spi(24'h800405, 1, 8'h11);
        spi(24'h800405, 0, 8'h00);
        cycle(); chk("t4_rb", smp_spi, 8'h11);
        spi(24'h0, 1, 8'h00);
        cycle(); chk("t4_release", smp_crst, 0);

        // Saturation, then clear
        c_req = 1; s_en = 1; s_addr = 24'h800409; s_wr = 0;
        repeat (32'h10005) cycle();
        s_en = 0; c_req = 0;
        rd_ctl(2'd3, v); chk("t5_stall_h", v, 8'hFF);
        rd_ctl(2'd2, v); chk("t5_stall_l", v, 8'hFF);
        rd_ctl(2'd1, v); chk("t5_sat", v[2], 1);
        c_req = 1; spi(24'h000002, 1, 8'h5C); c_req = 0;
        rd_ctl(2'd2, v); chk("t5_clr_l", v, 8'h00);
        rd_ctl(2'd3, v); chk("t5_clr_h", v, 8'h00);

        // Reset mid-burst
        spi(24'h0, 1, 8'h01);
        spi(24'h80040A, 0, 0);
        rst = 1; cycle();
        chk("t6_spi", smp_spi, 8'h00); chk("t6_en", smp_en, 0);
        rst = 0;
        rd_ctl(2'd0, v); chk("t6_ctrl", v, {6'b0, CRST});
        c_req = 1; c_addr = 16'h0409; cycle();
        c_req = 0; cycle(); chk("t6_fetch", smp_di, 8'h99);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int kind;
            rst    = ($urandom_range(299) == 0);
            c_req  = ($urandom_range(3) != 0);
            c_we   = ($urandom_range(2) == 0);
            c_addr = 16'h0400 + 16'($urandom_range(31));
            c_do   = 8'($urandom);
            s_en   = ($urandom_range(2) == 0);
            s_wr   = $urandom_range(1);
            s_wd   = 8'($urandom);
            kind   = $urandom_range(7);
            if (kind < 6) s_addr = 24'h800400 + 24'($urandom_range(31));
            else begin
                s_addr = {1'b0, ($urandom_range(7) == 0) ? 21'($urandom) : 21'h0, 2'($urandom)};
                if (s_addr[1:0] == 2'd0 && $urandom_range(3) != 0) s_wd = 8'h00;
            end
            cycle();
        end
        rst = 0; s_en = 0; c_req = 0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
